result_collector: RTL and testbench

- Downstream stage of the CA-2 Controller/PU datapath.
- Each result-write strobe captures one of the four processing-unit results, chosen by the controller's res_mux code, into a first-word-fall-through FIFO.
- The FIFO is drained through a valid/ready stream, and each word carries an end-of-frame tag taken from the controller's done signal.
- The block also tracks overflow and counts completed frames.

---
 rtl/result_collector_if.sv | 31 +++
 rtl/result_collector.sv | 67 ++++++
 tb/tb_result_collector.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/result_collector_if.sv
// result_collector_if: PU result capture inputs and FWFT output stream of the result collector.
interface result_collector_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 4
);
    logic [DATA_W-1:0] pu_res0;
    logic [DATA_W-1:0] pu_res1;
    logic [DATA_W-1:0] pu_res2;
    logic [DATA_W-1:0] pu_res3;
    logic [1:0]        res_mux;
    logic              res_wr;
    logic              done;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [7:0]        frame_cnt;

    modport master (
        output pu_res0, pu_res1, pu_res2, pu_res3, res_mux, res_wr, done, out_ready,
        input  out_data, out_last, out_valid, full, count, overflow, frame_cnt
    );

    modport slave (
        input  pu_res0, pu_res1, pu_res2, pu_res3, res_mux, res_wr, done, out_ready,
        output out_data, out_last, out_valid, full, count, overflow, frame_cnt
    );
endinterface

// File: rtl/result_collector.sv
// result_collector: captures the selected PU result with its end-of-frame tag into a FWFT FIFO,
// tracks overflow and counts completed frames on the output stream.
module result_collector #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input logic               clk,
    input logic               rst,
    result_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        frm_q, frm_d;
    logic [DATA_W-1:0] sel;
    logic              full, empty, push, pop;
    logic [DATA_W:0]   head;

    assign full  = cnt_q == CNT_W'(DEPTH);
    assign empty = cnt_q == '0;
    assign pop   = !empty && bus.out_ready;
    assign push  = bus.res_wr && (!full || pop);
    assign sel   = bus.res_mux[1] ? (bus.res_mux[0] ? bus.pu_res3 : bus.pu_res2)
                                  : (bus.res_mux[0] ? bus.pu_res1 : bus.pu_res0);
    // Head is gated by occupancy so outputs read zero as soon as reset empties the FIFO.
    assign head  = empty ? '0 : mem_q[rd_q];

    always_comb begin
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        cnt_d = (push && !pop) ? cnt_q + CNT_W'(1) : (pop && !push) ? cnt_q - CNT_W'(1) : cnt_q;
        ovf_d = ovf_q || (bus.res_wr && !push);
        frm_d = (pop && head[DATA_W]) ? frm_q + 8'd1 : frm_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            frm_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            frm_q <= frm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {bus.done, sel};
    end

    assign bus.out_data  = head[DATA_W-1:0];
    assign bus.out_last  = head[DATA_W];
    assign bus.out_valid = !empty;
    assign bus.full      = full;
    assign bus.count     = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.frame_cnt = frm_q;
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed vectors with hand-computed expectations for result_collector.
module tb_result_collector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    result_collector_if #(.DATA_W(16), .CNT_W(4)) bif ();

    result_collector #(.DATA_W(16), .DEPTH(8), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_count"}, 32'(bif.count), 0);
        chk({tag, "_valid"}, 32'(bif.out_valid), 0);
        chk({tag, "_full"}, 32'(bif.full), 0);
        chk({tag, "_ovf"}, 32'(bif.overflow), 0);
        chk({tag, "_frame"}, 32'(bif.frame_cnt), 0);
    endtask

    initial begin
        bif.pu_res0 = '0; bif.pu_res1 = '0; bif.pu_res2 = '0; bif.pu_res3 = '0;
        bif.res_mux = '0; bif.res_wr = 1'b0; bif.done = 1'b0; bif.out_ready = 1'b0;
        step(); step();
        chk_zero("in_reset");
        rst = 1'b1;
        step();
        chk_zero("idle");

        // Mux capture
        bif.pu_res0 = 16'h0011; bif.pu_res1 = 16'h0022; bif.pu_res2 = 16'h0033; bif.pu_res3 = 16'h0044;
        bif.res_wr = 1'b1;
        bif.res_mux = 2'd3; step();
        chk("fall_through_data", 32'(bif.out_data), 32'h0044);
        chk("fall_through_valid", 32'(bif.out_valid), 1);
        bif.res_mux = 2'd0; step();
        bif.res_mux = 2'd2; step();
        bif.res_mux = 2'd1; bif.done = 1'b1; step();
        bif.res_wr = 1'b0; bif.done = 1'b0; bif.res_mux = 2'd3;
        chk("mux_count4", 32'(bif.count), 4);
        bif.out_ready = 1'b1;
        chk("mux_pop0", 32'(bif.out_data), 32'h0044); chk("mux_last0", 32'(bif.out_last), 0); step();
        chk("mux_pop1", 32'(bif.out_data), 32'h0011); chk("mux_last1", 32'(bif.out_last), 0); step();
        chk("mux_pop2", 32'(bif.out_data), 32'h0033); chk("mux_last2", 32'(bif.out_last), 0); step();
        chk("mux_pop3", 32'(bif.out_data), 32'h0022); chk("mux_last3", 32'(bif.out_last), 1);
        chk("mux_frame_before", 32'(bif.frame_cnt), 0); step();
        chk("mux_frame_after", 32'(bif.frame_cnt), 1);
        chk("mux_count0", 32'(bif.count), 0);
        chk("mux_valid0", 32'(bif.out_valid), 0);
        step();
        chk("empty_pop_noeffect", 32'(bif.count), 0);
        chk("empty_pop_frame", 32'(bif.frame_cnt), 1);
        bif.out_ready = 1'b0;

        // Fill and overflow
        bif.res_mux = 2'd0; bif.res_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bif.pu_res0 = 16'h0100 + 16'(i);
            step();
        end
        chk("fill_full", 32'(bif.full), 1);
        chk("fill_count", 32'(bif.count), 8);
        chk("fill_ovf0", 32'(bif.overflow), 0);
        bif.pu_res0 = 16'h0999; step();
        bif.res_wr = 1'b0;
        chk("ovf_count", 32'(bif.count), 8);
        chk("ovf_set", 32'(bif.overflow), 1);
        chk("ovf_head", 32'(bif.out_data), 32'h0100);
        bif.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(bif.out_data), 32'h0100 + 32'(i));
            step();
        end
        bif.out_ready = 1'b0;
        chk("drain_count", 32'(bif.count), 0);
        chk("drain_ovf_sticky", 32'(bif.overflow), 1);

        // Simultaneous push/pop at full
        rst = 1'b0; step(); rst = 1'b1;
        chk("rst2_ovf", 32'(bif.overflow), 0);
        bif.res_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bif.pu_res0 = 16'h0200 + 16'(i);
            step();
        end
        bif.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bif.pu_res0 = 16'h0300 + 16'(k);
            chk($sformatf("pp_head%0d", k), 32'(bif.out_data), 32'h0200 + 32'(k));
            step();
            chk($sformatf("pp_count%0d", k), 32'(bif.count), 8);
            chk($sformatf("pp_full%0d", k), 32'(bif.full), 1);
        end
        bif.res_wr = 1'b0;
        chk("pp_ovf", 32'(bif.overflow), 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_drain%0d", i), 32'(bif.out_data),
                i < 3 ? 32'h0205 + 32'(i) : 32'h0300 + 32'(i - 3));
            step();
        end
        chk("pp_empty", 32'(bif.count), 0);
        bif.out_ready = 1'b0;

        // Back-pressure stability
        bif.pu_res1 = 16'hBEEF; bif.res_mux = 2'd1; bif.res_wr = 1'b1; step();
        chk("bp_head1", 32'(bif.out_data), 32'hBEEF); chk("bp_count1", 32'(bif.count), 1);
        bif.pu_res2 = 16'h1111; bif.res_mux = 2'd2; step();
        chk("bp_head2", 32'(bif.out_data), 32'hBEEF); chk("bp_valid2", 32'(bif.out_valid), 1);
        bif.pu_res2 = 16'h2222; step();
        bif.res_wr = 1'b0;
        chk("bp_head3", 32'(bif.out_data), 32'hBEEF); chk("bp_count3", 32'(bif.count), 3);
        step();
        chk("bp_head4", 32'(bif.out_data), 32'hBEEF); chk("bp_valid4", 32'(bif.out_valid), 1);
        bif.out_ready = 1'b1;
        step(); step(); step();
        chk("bp_drained", 32'(bif.count), 0);

        // Build count=5, frame_cnt=3, overflow=1
        bif.out_ready = 1'b0; bif.res_mux = 2'd0; bif.res_wr = 1'b1; bif.done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.pu_res0 = 16'h0400 + 16'(i);
            step();
        end
        bif.res_wr = 1'b0; bif.done = 1'b1; bif.out_ready = 1'b1;
        step(); step(); step();
        chk("frames3", 32'(bif.frame_cnt), 3);
        bif.out_ready = 1'b0; bif.done = 1'b0; bif.res_wr = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bif.pu_res0 = 16'h0500 + 16'(i);
            step();
        end
        bif.res_wr = 1'b0; bif.out_ready = 1'b1;
        step(); step(); step();
        bif.out_ready = 1'b0;
        chk("pre_rst_count", 32'(bif.count), 5);
        chk("pre_rst_frame", 32'(bif.frame_cnt), 3);
        chk("pre_rst_ovf", 32'(bif.overflow), 1);
        chk("pre_rst_head", 32'(bif.out_data), 32'h0503);

        // Mid-operation asynchronous reset
        #2 rst = 1'b0;
        #1;
        chk_zero("async_rst");
        chk("async_rst_data", 32'(bif.out_data), 0);
        chk("async_rst_last", 32'(bif.out_last), 0);
        step();
        rst = 1'b1;
        bif.pu_res3 = 16'hCAFE; bif.res_mux = 2'd3; bif.res_wr = 1'b1;
        step();
        bif.res_wr = 1'b0;
        chk("post_rst_count", 32'(bif.count), 1);
        chk("post_rst_head", 32'(bif.out_data), 32'hCAFE);
        chk("post_rst_valid", 32'(bif.out_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
